wave_sum_tree: RTL and testbench

//  Parametrised successor to the fixed 16-channel wave summer. Sums N_CH signed channel samples

---
 rtl/wave_pkg.sv | 28 ++
 rtl/sum_tree_level.sv | 44 ++++
 rtl/wave_sum_tree.sv | 165 ++++++++++++++++
 tb/tb_wave_sum_tree.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared constants and helpers for the wave-generation blocks.
package wave_pkg;

  localparam int unsigned DEF_SAMPLE_W = 16;
  localparam int unsigned DEF_OUT_W    = 16;
  localparam int unsigned SHIFT_W      = 4;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r = r + 1;
    return r;
  endfunction

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/sum_tree_level.sv
// One registered adder-tree level: IN_N signed inputs -> IN_N/2 pairwise sums one bit wider.
module sum_tree_level
  import wave_pkg::*;
#(
  parameter int unsigned IN_N = 2,
  parameter int unsigned IN_W = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               valid,
  input  logic [SHIFT_W-1:0]                 shift,
  input  logic [IN_N*IN_W-1:0]               data,
  output logic                               sum_valid,
  output logic [SHIFT_W-1:0]                 sum_shift,
  output logic [(IN_N/2)*(IN_W+1)-1:0]       sums
);

  localparam int unsigned OUT_N = IN_N / 2;
  localparam int unsigned OW    = IN_W + 1;

  logic [OUT_N*OW-1:0] sums_c;

  // Sign-extend both operands so the add can never wrap.
  always_comb begin
    sums_c = '0;
    for (int i = 0; i < OUT_N; i++) begin
      sums_c[i*OW +: OW] = OW'($signed(data[(2*i)*IN_W +: IN_W]))
                         + OW'($signed(data[(2*i+1)*IN_W +: IN_W]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_valid <= 1'b0;
      sum_shift <= '0;
      sums      <= '0;
    end else begin
      sum_valid <= valid;
      sum_shift <= shift;
      sums      <= sums_c;
    end
  end

endmodule

// File: rtl/wave_sum_tree.sv
// Masked, pipelined N_CH-channel sum with rounding gain shift, saturation and sticky overflow.
// Optional peak-magnitude tracker enabled by defining WAVE_SUM_PEAK_EN.
module wave_sum_tree
  import wave_pkg::*;
#(
  parameter int unsigned N_CH     = 16,
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
  parameter int unsigned OUT_W    = DEF_OUT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [N_CH*SAMPLE_W-1:0]   samples,
  input  logic [N_CH-1:0]            ch_en,
  input  logic [SHIFT_W-1:0]         shift,
  input  logic                       clr_ovf,
`ifdef WAVE_SUM_PEAK_EN
  input  logic                       clr_peak,
  output logic [OUT_W-1:0]           peak,
`endif
  output logic                       out_valid,
  output logic signed [OUT_W-1:0]    result,
  output logic                       ovf_sticky
);

  localparam int unsigned L     = clog2(N_CH);
  localparam int unsigned SUM_W = SAMPLE_W + L;
  localparam int unsigned RND_W = SUM_W + 1;

  // Bit offset of tree level k inside the flat inter-level bus.
  function automatic int unsigned lvl_off(input int unsigned k);
    int unsigned o;
    o = 0;
    for (int unsigned j = 0; j < k; j++) o = o + (N_CH >> j) * (SAMPLE_W + j);
    return o;
  endfunction

  localparam int unsigned TOT_W = lvl_off(L + 1);

  wire [TOT_W-1:0]         lvl_data;
  wire [L:0]               lvl_valid;
  wire [(L+1)*SHIFT_W-1:0] lvl_shift;

  logic [N_CH*SAMPLE_W-1:0] masked_c;
  logic [N_CH*SAMPLE_W-1:0] s0_data;
  logic                     s0_valid;
  logic [SHIFT_W-1:0]       s0_shift;

  always_comb begin
    masked_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      masked_c[i*SAMPLE_W +: SAMPLE_W] = ch_en[i] ? samples[i*SAMPLE_W +: SAMPLE_W]
                                                  : SAMPLE_W'(0);
    end
  end

  // Stage 0: masked samples with their shift setting travel together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_data  <= '0;
      s0_valid <= 1'b0;
      s0_shift <= '0;
    end else begin
      s0_data  <= masked_c;
      s0_valid <= in_valid;
      s0_shift <= shift;
    end
  end

  assign lvl_data[0 +: N_CH*SAMPLE_W] = s0_data;
  assign lvl_valid[0]                 = s0_valid;
  assign lvl_shift[0 +: SHIFT_W]      = s0_shift;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int unsigned IN_N    = N_CH >> k;
    localparam int unsigned IN_W    = SAMPLE_W + k;
    localparam int unsigned IN_OFF  = lvl_off(k);
    localparam int unsigned OUT_OFF = lvl_off(k + 1);

    sum_tree_level #(
      .IN_N (IN_N),
      .IN_W (IN_W)
    ) u_level (
      .clk       (clk),
      .reset     (reset),
      .valid     (lvl_valid[k]),
      .shift     (lvl_shift[k*SHIFT_W +: SHIFT_W]),
      .data      (lvl_data[IN_OFF +: IN_N*IN_W]),
      .sum_valid (lvl_valid[k+1]),
      .sum_shift (lvl_shift[(k+1)*SHIFT_W +: SHIFT_W]),
      .sums      (lvl_data[OUT_OFF +: (IN_N/2)*(IN_W+1)])
    );
  end

  logic signed [SUM_W-1:0] tree_sum;
  logic [SHIFT_W-1:0]      tree_shift;
  assign tree_sum   = lvl_data[lvl_off(L) +: SUM_W];
  assign tree_shift = lvl_shift[L*SHIFT_W +: SHIFT_W];

  int unsigned             sh_amt_c;
  logic signed [RND_W-1:0] rnd_c;
  logic signed [RND_W-1:0] rnd_q;
  logic                    rnd_valid;

  // Round half up: one extra bit absorbs the rounding increment.
  always_comb begin
    sh_amt_c = 32'(tree_shift);
    if (sh_amt_c > SUM_W - 1) sh_amt_c = SUM_W - 1;
    rnd_c = RND_W'(tree_sum);
    if (sh_amt_c != 0) rnd_c = rnd_c + (RND_W'(1) << (sh_amt_c - 1));
    rnd_c = rnd_c >>> sh_amt_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rnd_q     <= '0;
      rnd_valid <= 1'b0;
    end else begin
      rnd_q     <= rnd_c;
      rnd_valid <= lvl_valid[L];
    end
  end

  logic signed [63:0] sat_c;
  logic               sat_hit_c;

  always_comb begin
    sat_c     = saturate(64'(rnd_q), OUT_W);
    sat_hit_c = (sat_c != 64'(rnd_q));
  end

  // Overflow set takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      result     <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      out_valid <= rnd_valid;
      if (rnd_valid) result <= OUT_W'(sat_c);
      if (rnd_valid && sat_hit_c) ovf_sticky <= 1'b1;
      else if (clr_ovf)           ovf_sticky <= 1'b0;
    end
  end

`ifdef WAVE_SUM_PEAK_EN
  logic [OUT_W-1:0] abs_c;

  // Magnitude fits unsigned OUT_W, including the most negative value.
  always_comb begin
    abs_c = sat_c[63] ? OUT_W'(-sat_c) : OUT_W'(sat_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak <= '0;
    end else if (rnd_valid) begin
      if (clr_peak || abs_c > peak) peak <= abs_c;
    end else if (clr_peak) begin
      peak <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_wave_sum_tree.sv
// Directed-vector bench for wave_sum_tree (16 channels, 16-bit samples and result).
module tb_wave_sum_tree;

  localparam int unsigned N  = 16;
  localparam int unsigned W  = 16;
  localparam int unsigned OW = 16;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic [N*W-1:0]        samples;
  logic [N-1:0]          ch_en;
  logic [3:0]            shift;
  logic                  clr_ovf;
  logic                  out_valid;
  logic signed [OW-1:0]  result;
  logic                  ovf_sticky;
`ifdef WAVE_SUM_PEAK_EN
  logic                  clr_peak;
  logic [OW-1:0]         peak;
`endif

  int n_checks = 0;
  int n_errors = 0;

  wave_sum_tree #(.N_CH(N), .SAMPLE_W(W), .OUT_W(OW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .samples    (samples),
    .ch_en      (ch_en),
    .shift      (shift),
    .clr_ovf    (clr_ovf),
`ifdef WAVE_SUM_PEAK_EN
    .clr_peak   (clr_peak),
    .peak       (peak),
`endif
    .out_valid  (out_valid),
    .result     (result),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] fill(input logic signed [W-1:0] ch0,
                                          input logic signed [W-1:0] rest);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = (i == 0) ? ch0 : rest;
    return v;
  endfunction

  task automatic send(input logic [N*W-1:0] s, input logic [N-1:0] en, input logic [3:0] sh);
    samples  = s;
    ch_en    = en;
    shift    = sh;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    samples  = '0;
    ch_en    = '0;
    shift    = '0;
    clr_ovf  = 1'b0;
`ifdef WAVE_SUM_PEAK_EN
    clr_peak = 1'b0;
`endif
    #2 reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (result !== 16'sd0) begin n_errors++; $display("FAIL reset_result: got %0d want 0", result); end
    n_checks++; if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", ovf_sticky); end
`ifdef WAVE_SUM_PEAK_EN
    n_checks++; if (peak !== 16'd0) begin n_errors++; $display("FAIL reset_peak: got %0d want 0", peak); end
`endif
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    send(fill(16'sd1000, 16'sd1000), 16'hFFFF, 4'd0);
    wait_out(n);
    n_checks++; if (n !== 6) begin n_errors++; $display("FAIL basic_latency: got %0d want 6", n); end
    n_checks++; if (result !== 16'sd16000) begin n_errors++; $display("FAIL basic_result: got %0d want 16000", result); end
    n_checks++; if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL basic_ovf: got %b want 0", ovf_sticky); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_single_pulse: got %b want 0", out_valid); end
  endtask

  task automatic test_saturate_pos();
    int n;
    send(fill(16'sd32767, 16'sd32767), 16'hFFFF, 4'd0);
    wait_out(n);
    n_checks++; if (n !== 6) begin n_errors++; $display("FAIL satpos_latency: got %0d want 6", n); end
    n_checks++; if (result !== 16'sd32767) begin n_errors++; $display("FAIL satpos_result: got %0d want 32767", result); end
    n_checks++; if (ovf_sticky !== 1'b1) begin n_errors++; $display("FAIL satpos_ovf: got %b want 1", ovf_sticky); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++; if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL satpos_clear: got %b want 0", ovf_sticky); end
    send(fill(16'sd32767, 16'sd32767), 16'hFFFF, 4'd4);
    wait_out(n);
    n_checks++; if (result !== 16'sd32767) begin n_errors++; $display("FAIL shift4_result: got %0d want 32767", result); end
    n_checks++; if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL shift4_ovf: got %b want 0", ovf_sticky); end
  endtask

  task automatic test_saturate_neg();
    int n;
    send(fill(-16'sd32768, -16'sd32768), 16'hFFFF, 4'd0);
    wait_out(n);
    n_checks++; if (result !== -16'sd32768) begin n_errors++; $display("FAIL satneg_result: got %0d want -32768", result); end
    n_checks++; if (ovf_sticky !== 1'b1) begin n_errors++; $display("FAIL satneg_ovf: got %b want 1", ovf_sticky); end
    send(fill(-16'sd32768, -16'sd32768), 16'hFFFF, 4'd0);
    for (int i = 0; i < 5; i++) tick();
    clr_ovf = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL setclr_out_valid: got %b want 1", out_valid); end
    n_checks++; if (ovf_sticky !== 1'b1) begin n_errors++; $display("FAIL set_wins_over_clr: got %b want 1", ovf_sticky); end
    tick();
    clr_ovf = 1'b0;
    n_checks++; if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL clr_alone: got %b want 0", ovf_sticky); end
  endtask

  task automatic test_round();
    int n;
    send(fill(-16'sd5, 16'sd30000), 16'h0001, 4'd1);
    wait_out(n);
    n_checks++; if (result !== -16'sd2) begin n_errors++; $display("FAIL round_neg: got %0d want -2", result); end
    send(fill(16'sd3, 16'sd30000), 16'h0001, 4'd1);
    wait_out(n);
    n_checks++; if (result !== 16'sd2) begin n_errors++; $display("FAIL round_pos: got %0d want 2", result); end
    send(fill(-16'sd32768, -16'sd32768), 16'hFFFF, 4'd15);
    wait_out(n);
    n_checks++; if (result !== -16'sd16) begin n_errors++; $display("FAIL shift15_result: got %0d want -16", result); end
    n_checks++; if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL shift15_ovf: got %b want 0", ovf_sticky); end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    logic signed [OW-1:0] exp_r;
    for (int it = 0; it < 30; it++) begin
      if (it < 20) begin
        samples  = fill(16'(it + 1), 16'sd0);
        ch_en    = 16'hFFFF;
        shift    = 4'd0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      exp_v = (it >= 6) && (it < 26);
      exp_r = 16'(it - 5);
      n_checks++; if (out_valid !== exp_v) begin n_errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", it, out_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (result !== exp_r) begin n_errors++; $display("FAIL b2b_result[%0d]: got %0d want %0d", it, result, exp_r); end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    int seen;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      samples  = fill(16'(7 + i), 16'sd0);
      ch_en    = 16'hFFFF;
      shift    = 4'd0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (result !== 16'sd0) begin n_errors++; $display("FAIL flight_result: got %0d want 0", result); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flight_out_valid: got %b want 0", out_valid); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL flight_discard: got %0d outputs want 0", seen); end
  endtask

`ifdef WAVE_SUM_PEAK_EN
  task automatic test_peak();
    int n;
    send(fill(-16'sd300, 16'sd0), 16'hFFFF, 4'd0);
    wait_out(n);
    n_checks++; if (result !== -16'sd300) begin n_errors++; $display("FAIL peak_neg_result: got %0d want -300", result); end
    send(fill(16'sd200, 16'sd0), 16'hFFFF, 4'd0);
    wait_out(n);
    n_checks++; if (peak !== 16'd300) begin n_errors++; $display("FAIL peak_value: got %0d want 300", peak); end
    clr_peak = 1'b1;
    tick();
    clr_peak = 1'b0;
    n_checks++; if (peak !== 16'd0) begin n_errors++; $display("FAIL peak_clear: got %0d want 0", peak); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_saturate_pos();
    test_saturate_neg();
    test_round();
    test_back_to_back();
    test_reset_in_flight();
`ifdef WAVE_SUM_PEAK_EN
    test_peak();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
